// File: rtl/decode_pipe_stage.sv
// Decode stage: 8-entry register file, immediate extension, load-use stall and ID/EX register.
// Define RF_BYPASS_EN to forward same-cycle write-back data onto the register reads.
module decode_pipe_stage #(
    parameter int DATA_W  = 16,
    parameter int R0_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [15:0]       instr,
    output logic              if_ready,
    input  logic [2:0]        dec_wr_sel,
    input  logic              dec_reg_write,
    input  logic              dec_mem_read,
    input  logic              dec_uses_rt,
    input  logic              dec_halt,
    input  logic [2:0]        imm_sel,
    input  logic              wb_en,
    input  logic [2:0]        wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [2:0]        ex_wr_sel,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [15:0]       ex_instr,
    output logic              halted,
    output logic              err
);

    logic [DATA_W-1:0] rf_reg [8];
    logic [2:0]        rs;
    logic [2:0]        rt;
    logic              rs_zero;
    logic              rt_zero;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_next;
    logic              imm_illegal;
    logic              stall;
    logic              accept;

    logic              ex_valid_reg;
    logic [DATA_W-1:0] ex_a_reg;
    logic [DATA_W-1:0] ex_b_reg;
    logic [DATA_W-1:0] ex_imm_reg;
    logic [2:0]        ex_wr_sel_reg;
    logic              ex_reg_write_reg;
    logic              ex_mem_read_reg;
    logic [15:0]       ex_instr_reg;
    logic              halted_reg;
    logic              err_reg;

    assign rs      = instr[10:8];
    assign rt      = instr[7:5];
    assign rs_zero = (R0_ZERO != 0) && (rs == 3'd0);
    assign rt_zero = (R0_ZERO != 0) && (rt == 3'd0);

    // One always_ff per entry so reset can clear the whole file at once.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rf
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rf_reg[gi] <= '0;
                end else if (wb_en && (wb_sel == 3'(gi)) && !((R0_ZERO != 0) && (gi == 0))) begin
                    rf_reg[gi] <= wb_data;
                end
            end
        end
    endgenerate

    always_comb begin
        rs_data = rs_zero ? '0 : rf_reg[rs];
        rt_data = rt_zero ? '0 : rf_reg[rt];
`ifdef RF_BYPASS_EN
        if (wb_en && (wb_sel == rs) && !rs_zero) rs_data = wb_data;
        if (wb_en && (wb_sel == rt) && !rt_zero) rt_data = wb_data;
`endif
    end

    always_comb begin
        imm_next    = '0;
        imm_illegal = 1'b0;
        case (imm_sel)
            3'd0:    imm_next = {{(DATA_W-5){instr[4]}}, instr[4:0]};
            3'd1:    imm_next = {{(DATA_W-5){1'b0}}, instr[4:0]};
            3'd2:    imm_next = {{(DATA_W-8){instr[7]}}, instr[7:0]};
            3'd3:    imm_next = {{(DATA_W-8){1'b0}}, instr[7:0]};
            3'd4:    imm_next = {{(DATA_W-11){instr[10]}}, instr[10:0]};
            default: imm_illegal = 1'b1;
        endcase
    end

    // A load still in ID/EX cannot forward its result yet, so its consumer waits one cycle.
    assign stall    = if_valid && ex_valid_reg && ex_mem_read_reg &&
                      ((ex_wr_sel_reg == rs) || (dec_uses_rt && (ex_wr_sel_reg == rt)));
    assign if_ready = flush || (!halted_reg && ex_ready && !stall);
    assign accept   = if_valid && if_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_reg     <= 1'b0;
            ex_a_reg         <= '0;
            ex_b_reg         <= '0;
            ex_imm_reg       <= '0;
            ex_wr_sel_reg    <= '0;
            ex_reg_write_reg <= 1'b0;
            ex_mem_read_reg  <= 1'b0;
            ex_instr_reg     <= '0;
            halted_reg       <= 1'b0;
            err_reg          <= 1'b0;
        end else if (flush) begin
            ex_valid_reg     <= 1'b0;
            ex_reg_write_reg <= 1'b0;
            ex_mem_read_reg  <= 1'b0;
        end else if (accept) begin
            ex_valid_reg     <= 1'b1;
            ex_a_reg         <= rs_data;
            ex_b_reg         <= rt_data;
            ex_imm_reg       <= imm_next;
            ex_wr_sel_reg    <= dec_wr_sel;
            ex_reg_write_reg <= dec_reg_write;
            ex_mem_read_reg  <= dec_mem_read;
            ex_instr_reg     <= instr;
            if (dec_halt)    halted_reg <= 1'b1;
            if (imm_illegal) err_reg    <= 1'b1;
        end else if (ex_ready) begin
            ex_valid_reg     <= 1'b0;
            ex_reg_write_reg <= 1'b0;
            ex_mem_read_reg  <= 1'b0;
        end
    end

    assign ex_valid     = ex_valid_reg;
    assign ex_a         = ex_a_reg;
    assign ex_b         = ex_b_reg;
    assign ex_imm       = ex_imm_reg;
    assign ex_wr_sel    = ex_wr_sel_reg;
    assign ex_reg_write = ex_reg_write_reg;
    assign ex_mem_read  = ex_mem_read_reg;
    assign ex_instr     = ex_instr_reg;
    assign halted       = halted_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage: reset, reads, load-use stall, bypass, immediates,
// hold/flush and halt. Expectations follow RF_BYPASS_EN when it is defined.
module tb_decode_pipe_stage;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [15:0] instr;
    logic        if_ready;
    logic [2:0]  dec_wr_sel;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_uses_rt;
    logic        dec_halt;
    logic [2:0]  imm_sel;
    logic        wb_en;
    logic [2:0]  wb_sel;
    logic [15:0] wb_data;
    logic        ex_ready;
    logic        flush;
    logic        ex_valid;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [15:0] ex_imm;
    logic [2:0]  ex_wr_sel;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [15:0] ex_instr;
    logic        halted;
    logic        err;

    int errors = 0;
    int checks = 0;

    decode_pipe_stage #(.DATA_W(16), .R0_ZERO(0)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instr(instr), .if_ready(if_ready),
        .dec_wr_sel(dec_wr_sel), .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
        .dec_uses_rt(dec_uses_rt), .dec_halt(dec_halt), .imm_sel(imm_sel),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .ex_ready(ex_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_wr_sel(ex_wr_sel),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_instr(ex_instr),
        .halted(halted), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mk(input logic [2:0] rs, input logic [2:0] rt, input logic [4:0] lo);
        return {5'b0, rs, rt, lo};
    endfunction

    task automatic idle();
        if_valid = 0; instr = '0; dec_wr_sel = '0; dec_reg_write = 0; dec_mem_read = 0;
        dec_uses_rt = 0; dec_halt = 0; imm_sel = '0; wb_en = 0; wb_sel = '0; wb_data = '0;
        ex_ready = 1; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #2;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b expected 0", ex_valid); end
        checks++;
        if (halted !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: got halted=%b err=%b expected 0/0", halted, err); end
        checks++;
        if (ex_a !== 16'h0 || ex_imm !== 16'h0 || ex_instr !== 16'h0) begin
            errors++; $display("FAIL reset_fields: got a=%h imm=%h instr=%h expected 0", ex_a, ex_imm, ex_instr);
        end
        checks++;
        rst = 1'b0;
        #1;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready: got %b expected 1", if_ready); end
        checks++;
        step();
        $display("test_reset done");
    endtask

    task automatic test_read();
        do_reset();
        wb_en = 1; wb_sel = 3'd3; wb_data = 16'h1234;
        step();
        wb_en = 0; if_valid = 1; instr = mk(3'd3, 3'd0, 5'h1F);
        dec_wr_sel = 3'd4; dec_reg_write = 1; imm_sel = 3'd0;
        #1;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL read_if_ready: got %b expected 1", if_ready); end
        checks++;
        step();
        if (ex_valid !== 1'b1 || ex_a !== 16'h1234) begin
            errors++; $display("FAIL read_ex_a: got valid=%b a=%h expected 1/1234", ex_valid, ex_a);
        end
        checks++;
        if (ex_imm !== 16'hFFFF || ex_wr_sel !== 3'd4 || ex_reg_write !== 1'b1 || ex_instr !== 16'h031F) begin
            errors++; $display("FAIL read_fields: got imm=%h wr_sel=%0d rw=%b instr=%h expected FFFF/4/1/031F",
                                ex_imm, ex_wr_sel, ex_reg_write, ex_instr);
        end
        checks++;
        idle();
        step();
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
            errors++; $display("FAIL read_bubble: got valid=%b rw=%b expected 0/0", ex_valid, ex_reg_write);
        end
        checks++;
        $display("test_read done");
    endtask

    task automatic test_load_use();
        do_reset();
        wb_en = 1; wb_sel = 3'd2; wb_data = 16'h2222;
        step();
        wb_en = 0; if_valid = 1; instr = mk(3'd0, 3'd0, 5'd0);
        dec_mem_read = 1; dec_reg_write = 1; dec_wr_sel = 3'd2;
        step();
        if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1) begin
            errors++; $display("FAIL stall_load: got valid=%b mr=%b expected 1/1", ex_valid, ex_mem_read);
        end
        checks++;
        instr = mk(3'd2, 3'd0, 5'd0); dec_mem_read = 0; dec_wr_sel = 3'd1;
        #1;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL stall_if_ready: got %b expected 0", if_ready); end
        checks++;
        step();
        if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin
            errors++; $display("FAIL stall_bubble: got valid=%b mr=%b expected 0/0", ex_valid, ex_mem_read);
        end
        checks++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", if_ready); end
        checks++;
        step();
        if (ex_valid !== 1'b1 || ex_a !== 16'h2222 || ex_instr !== 16'h0200) begin
            errors++; $display("FAIL stall_accept: got valid=%b a=%h instr=%h expected 1/2222/0200", ex_valid, ex_a, ex_instr);
        end
        checks++;
        // rt only matters as a hazard when the instruction actually uses rt
        instr = mk(3'd0, 3'd0, 5'd0); dec_mem_read = 1; dec_wr_sel = 3'd5;
        step();
        instr = mk(3'd1, 3'd5, 5'd0); dec_mem_read = 0; dec_uses_rt = 0;
        #1;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL stall_rt_unused: got %b expected 1", if_ready); end
        checks++;
        dec_uses_rt = 1;
        #1;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL stall_rt_used: got %b expected 0", if_ready); end
        checks++;
        idle();
        step();
        $display("test_load_use done");
    endtask

    task automatic test_bypass();
        logic [15:0] exp_b;
`ifdef RF_BYPASS_EN
        exp_b = 16'hBEEF;
`else
        exp_b = 16'h1111;
`endif
        do_reset();
        wb_en = 1; wb_sel = 3'd5; wb_data = 16'h1111;
        step();
        wb_data = 16'hBEEF; if_valid = 1; instr = mk(3'd0, 3'd5, 5'd0); dec_uses_rt = 1;
        #1;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL bypass_if_ready: got %b expected 1", if_ready); end
        checks++;
        step();
        if (ex_b !== exp_b) begin errors++; $display("FAIL bypass_same_cycle: got %h expected %h", ex_b, exp_b); end
        checks++;
        wb_en = 0;
        step();
        if (ex_b !== 16'hBEEF) begin errors++; $display("FAIL bypass_next_cycle: got %h expected BEEF", ex_b); end
        checks++;
        idle();
        step();
        $display("test_bypass done");
    endtask

    task automatic test_imm();
        do_reset();
        if_valid = 1; instr = 16'h0080; imm_sel = 3'd2;
        step();
        if (ex_imm !== 16'hFF80) begin errors++; $display("FAIL imm_sext8: got %h expected FF80", ex_imm); end
        checks++;
        imm_sel = 3'd3;
        step();
        if (ex_imm !== 16'h0080) begin errors++; $display("FAIL imm_zext8: got %h expected 0080", ex_imm); end
        checks++;
        instr = 16'h0480; imm_sel = 3'd4;
        step();
        if (ex_imm !== 16'hFC80) begin errors++; $display("FAIL imm_sext11: got %h expected FC80", ex_imm); end
        checks++;
        instr = 16'h001F; imm_sel = 3'd1;
        step();
        if (ex_imm !== 16'h001F) begin errors++; $display("FAIL imm_zext5: got %h expected 001F", ex_imm); end
        checks++;
        imm_sel = 3'd0;
        step();
        if (ex_imm !== 16'hFFFF || err !== 1'b0) begin
            errors++; $display("FAIL imm_sext5: got imm=%h err=%b expected FFFF/0", ex_imm, err);
        end
        checks++;
        imm_sel = 3'd6;
        step();
        if (err !== 1'b1 || ex_imm !== 16'h0 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL imm_illegal: got err=%b imm=%h valid=%b expected 1/0000/1", err, ex_imm, ex_valid);
        end
        checks++;
        idle();
        step();
        if (err !== 1'b1) begin errors++; $display("FAIL imm_err_sticky: got %b expected 1", err); end
        checks++;
        $display("test_imm done");
    endtask

    task automatic test_hold_flush();
        do_reset();
        if_valid = 1; instr = mk(3'd1, 3'd2, 5'd3); dec_wr_sel = 3'd3; dec_reg_write = 1;
        step();
        ex_ready = 0; instr = mk(3'd4, 3'd5, 5'd6); dec_wr_sel = 3'd6;
        #1;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL hold_if_ready: got %b expected 0", if_ready); end
        checks++;
        step();
        if (ex_valid !== 1'b1 || ex_instr !== 16'h0143 || ex_wr_sel !== 3'd3 || ex_reg_write !== 1'b1) begin
            errors++; $display("FAIL hold_outputs: got valid=%b instr=%h wr_sel=%0d rw=%b expected 1/0143/3/1",
                                ex_valid, ex_instr, ex_wr_sel, ex_reg_write);
        end
        checks++;
        flush = 1; dec_halt = 1; imm_sel = 3'd7;
        #1;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL flush_if_ready: got %b expected 1", if_ready); end
        checks++;
        step();
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_ex_valid: got %b expected 0", ex_valid); end
        checks++;
        if (halted !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL flush_flags: got halted=%b err=%b expected 0/0", halted, err);
        end
        checks++;
        flush = 0; dec_halt = 0; imm_sel = 3'd0;
        step();
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty: got %b expected 0", ex_valid); end
        checks++;
        idle();
        step();
        $display("test_hold_flush done");
    endtask

    task automatic test_halt();
        do_reset();
        if_valid = 1; instr = mk(3'd1, 3'd0, 5'd0); dec_halt = 1;
        step();
        if (halted !== 1'b1 || ex_valid !== 1'b1 || ex_instr !== 16'h0100) begin
            errors++; $display("FAIL halt_accept: got halted=%b valid=%b instr=%h expected 1/1/0100", halted, ex_valid, ex_instr);
        end
        checks++;
        dec_halt = 0; instr = mk(3'd2, 3'd0, 5'd0);
        #1;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL halt_if_ready: got %b expected 0", if_ready); end
        checks++;
        step();
        step();
        if (ex_valid !== 1'b0 || halted !== 1'b1) begin
            errors++; $display("FAIL halt_no_accept: got valid=%b halted=%b expected 0/1", ex_valid, halted);
        end
        checks++;
        rst = 1'b1;
        #1;
        if (halted !== 1'b0 || ex_valid !== 1'b0) begin
            errors++; $display("FAIL halt_reset: got halted=%b valid=%b expected 0/0", halted, ex_valid);
        end
        checks++;
        rst = 1'b0;
        #1;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL halt_reset_ready: got %b expected 1", if_ready); end
        checks++;
        step();
        if (ex_valid !== 1'b1 || ex_instr !== 16'h0200) begin
            errors++; $display("FAIL halt_resume: got valid=%b instr=%h expected 1/0200", ex_valid, ex_instr);
        end
        checks++;
        idle();
        step();
        $display("test_halt done");
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_read();
        test_load_use();
        test_bypass();
        test_imm();
        test_hold_flush();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
